osc_freq_meter: RTL and testbench

- Measures the frequency of the on-chip oscillator output, or a prescaled copy of it, against the board crystal clock. It answers "is the internal OSC alive and in tolerance".
- Counts rising edges of the asynchronous input sig_in over a fixed gate window of sys_clk cycles. Reports the count, a range check and a dead-oscillator flag once per window.
- Sits beside the OSC wrapper and feeds status LEDs or LCD debug overlays.

---
 rtl/osc_freq_meter.sv | 149 ++++++++++++++
 tb/tb_osc_freq_meter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/osc_freq_meter.sv
// Oscillator frequency meter: counts synchronized rising edges of sig_in over
// back-to-back gate windows of sys_clk cycles and reports count, range and liveness.
module osc_freq_meter #(
  parameter int unsigned GATE_CYCLES = 27000000,
  parameter int          CNT_W       = 32,
  parameter int unsigned LO_LIMIT    = 0,
  parameter int unsigned HI_LIMIT    = 32'hFFFF_FFFF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_count,
  output logic             count_valid,
  output logic             in_range,
  output logic             dead,
  output logic             overflow
);

  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0] SETTLE_END = GATE_W'(2);
  localparam logic [CNT_W-1:0]  LO_L       = CNT_W'(LO_LIMIT);
  localparam logic [CNT_W-1:0]  HI_L       = CNT_W'(HI_LIMIT);

  typedef enum logic [1:0] {IDLE, SETTLE, GATE} state_t;

  state_t              state_q, state_d;
  logic                s1_q, s2_q, s3_q;
  logic [GATE_W-1:0]   gate_q, gate_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sat_q, sat_d;
  logic [CNT_W-1:0]    freq_count_q, freq_count_d;
  logic                count_valid_q, count_valid_d;
  logic                in_range_q, in_range_d;
  logic                dead_q, dead_d;
  logic                overflow_q, overflow_d;

  logic                edge_det;
  logic                sat_hit;
  logic [CNT_W-1:0]    cnt_fin;

  // Saturating increment; MSB of the result flags an increment attempted at full scale.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    if (inc && (&c)) return {1'b1, c};
    return {1'b0, c + CNT_W'(inc)};
  endfunction

  // Offset compare keeps the check unsigned and free of constant-zero bounds.
  function automatic logic range_ok(input logic [CNT_W-1:0] c);
    return (c - LO_L) <= (HI_L - LO_L);
  endfunction

  assign edge_det           = s2_q & ~s3_q;
  assign {sat_hit, cnt_fin} = sat_inc(cnt_q, edge_det);

  always_comb begin
    state_d       = state_q;
    gate_d        = gate_q;
    cnt_d         = cnt_q;
    sat_d         = sat_q;
    freq_count_d  = freq_count_q;
    in_range_d    = in_range_q;
    dead_d        = dead_q;
    overflow_d    = overflow_q;
    count_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        gate_d = '0;
        cnt_d  = '0;
        sat_d  = 1'b0;
        if (enable) state_d = SETTLE;
      end
      SETTLE: begin
        cnt_d = '0;
        sat_d = 1'b0;
        if (!enable) begin
          state_d = IDLE;
          gate_d  = '0;
        end else if (gate_q == SETTLE_END) begin
          state_d = GATE;
          gate_d  = '0;
        end else begin
          gate_d = gate_q + GATE_W'(1);
        end
      end
      GATE: begin
        if (!enable) begin
          state_d = IDLE;
          gate_d  = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end else if (gate_q == GATE_LAST) begin
          // Latch includes this cycle's edge; the next window starts on the same edge.
          freq_count_d  = cnt_fin;
          in_range_d    = range_ok(cnt_fin);
          dead_d        = (cnt_fin == '0);
          overflow_d    = sat_q | sat_hit;
          count_valid_d = 1'b1;
          gate_d        = '0;
          cnt_d         = '0;
          sat_d         = 1'b0;
        end else begin
          gate_d = gate_q + GATE_W'(1);
          cnt_d  = cnt_fin;
          sat_d  = sat_q | sat_hit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      gate_q        <= '0;
      cnt_q         <= '0;
      sat_q         <= 1'b0;
      freq_count_q  <= '0;
      count_valid_q <= 1'b0;
      in_range_q    <= 1'b0;
      dead_q        <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      s1_q          <= sig_in;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      gate_q        <= gate_d;
      cnt_q         <= cnt_d;
      sat_q         <= sat_d;
      freq_count_q  <= freq_count_d;
      count_valid_q <= count_valid_d;
      in_range_q    <= in_range_d;
      dead_q        <= dead_d;
      overflow_q    <= overflow_d;
    end
  end

  assign freq_count  = freq_count_q;
  assign count_valid = count_valid_q;
  assign in_range    = in_range_q;
  assign dead        = dead_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_osc_freq_meter.sv
// Scoreboard bench for osc_freq_meter: a 32-bit meter for nominal/stuck/range/abort
// cases and a 4-bit meter for counter saturation.
module tb_osc_freq_meter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        enable_a, enable_b;
  logic        sig_a = 1'b0, sig_b = 1'b0;
  logic [31:0] freq_count_a;
  logic [3:0]  freq_count_b;
  logic        count_valid_a, in_range_a, dead_a, overflow_a;
  logic        count_valid_b, in_range_b, dead_b, overflow_b;

  int          per_a = 4, per_b = 0;
  logic        lvl_a = 1'b0, lvl_b = 1'b0;
  int          ph_a = 0, ph_b = 0;
  longint      cyc = 0;
  int          vectors = 0, miscompares = 0;
  int          pulses = 0;

  typedef struct {
    longint      lo, hi;
    bit          rng, dd, ovf;
    longint      when;
  } exp_t;
  exp_t q_a[$], q_b[$];

  osc_freq_meter #(.GATE_CYCLES(100), .CNT_W(32), .LO_LIMIT(9), .HI_LIMIT(11)) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable_a), .sig_in(sig_a),
    .freq_count(freq_count_a), .count_valid(count_valid_a), .in_range(in_range_a),
    .dead(dead_a), .overflow(overflow_a));

  osc_freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .LO_LIMIT(9), .HI_LIMIT(11)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable_b), .sig_in(sig_b),
    .freq_count(freq_count_b), .count_valid(count_valid_b), .in_range(in_range_b),
    .dead(dead_b), .overflow(overflow_b));

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Test signals change on the falling edge; period 0 holds the level.
  initial forever begin
    @(negedge sys_clk);
    if (per_a == 0) sig_a = lvl_a;
    else begin ph_a = (ph_a + 1) % per_a; sig_a = (ph_a < per_a / 2); end
    if (per_b == 0) sig_b = lvl_b;
    else begin ph_b = (ph_b + 1) % per_b; sig_b = (ph_b < per_b / 2); end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic compare(input string tag, input exp_t e, input longint cnt,
                         input logic rng, input logic dd, input logic ovf);
    chk_rng({tag, "_count"}, cnt, e.lo, e.hi);
    chk({tag, "_in_range"}, longint'(rng), longint'(e.rng));
    chk({tag, "_dead"}, longint'(dd), longint'(e.dd));
    chk({tag, "_overflow"}, longint'(ovf), longint'(e.ovf));
    if (e.when >= 0) chk({tag, "_valid_cycle"}, cyc, e.when);
  endtask

  // Monitors: every count_valid pulse is matched against the scoreboard head.
  always @(negedge sys_clk) begin
    if (count_valid_a === 1'b1) begin
      pulses++;
      if (q_a.size() == 0) chk("unexpected_valid_a", 1, 0);
      else compare("a", q_a.pop_front(), longint'(freq_count_a), in_range_a, dead_a, overflow_a);
    end
  end

  always @(negedge sys_clk) begin
    if (count_valid_b === 1'b1) begin
      pulses++;
      if (q_b.size() == 0) chk("unexpected_valid_b", 1, 0);
      else compare("b", q_b.pop_front(), longint'(freq_count_b), in_range_b, dead_b, overflow_b);
    end
  end

  task automatic push_a(input int n, input longint lo, input longint hi, input bit rng,
                        input bit dd, input bit ovf, input longint t0);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.lo = lo; e.hi = hi; e.rng = rng; e.dd = dd; e.ovf = ovf;
      e.when = t0 + 104 + 100 * k;
      q_a.push_back(e);
    end
  endtask

  task automatic drain(input int max_cyc);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      if (q_a.size() == 0 && q_b.size() == 0) break;
      @(negedge sys_clk);
    end
    if (i == max_cyc) chk("drain_timeout", longint'(q_a.size() + q_b.size()), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  initial begin
    longint t0;
    exp_t   eb;
    sys_rst = 1'b1; enable_a = 1'b0; enable_b = 1'b0;
    idle(2);
    chk("rst_freq_count", longint'(freq_count_a), 0);
    chk("rst_count_valid", longint'(count_valid_a), 0);
    chk("rst_in_range", longint'(in_range_a), 0);
    chk("rst_dead", longint'(dead_a), 0);
    chk("rst_overflow", longint'(overflow_a), 0);
    chk("rst_freq_count_b", longint'(freq_count_b), 0);
    sys_rst = 1'b0;
    idle(500);
    chk("idle_no_valid", longint'(pulses), 0);

    // Nominal: period 10 -> 10 edges per 100-cycle window.
    per_a = 10; idle(20);
    enable_a = 1'b1; t0 = cyc;
    push_a(3, 10, 10, 1, 0, 0, t0);
    drain(400);

    // Abort mid-window: no pulse, previous result held, restart takes a full settle.
    idle(50);
    enable_a = 1'b0;
    idle(200);
    chk("held_freq_count", longint'(freq_count_a), 10);
    chk("held_in_range", longint'(in_range_a), 1);
    chk("held_dead", longint'(dead_a), 0);
    enable_a = 1'b1; t0 = cyc;
    push_a(1, 10, 10, 1, 0, 0, t0);
    drain(300);
    enable_a = 1'b0;

    // Stuck low, then stuck high.
    per_a = 0; lvl_a = 1'b0; idle(20);
    enable_a = 1'b1; t0 = cyc;
    push_a(2, 0, 0, 0, 1, 0, t0);
    drain(300);
    enable_a = 1'b0;
    lvl_a = 1'b1; idle(20);
    enable_a = 1'b1; t0 = cyc;
    push_a(2, 0, 0, 0, 1, 0, t0);
    drain(300);
    enable_a = 1'b0;

    // Too fast: period 6 -> 16 or 17 edges.
    per_a = 6; idle(20);
    enable_a = 1'b1; t0 = cyc;
    push_a(2, 16, 17, 0, 0, 0, t0);
    drain(300);
    enable_a = 1'b0;

    // 4-bit counter sees 25 edges and saturates.
    per_b = 4; idle(20);
    enable_b = 1'b1; t0 = cyc;
    for (int k = 0; k < 2; k++) begin
      eb.lo = 15; eb.hi = 15; eb.rng = 0; eb.dd = 0; eb.ovf = 1;
      eb.when = t0 + 104 + 100 * k;
      q_b.push_back(eb);
    end
    drain(300);
    enable_b = 1'b0;

    // Reset in the middle of a window clears everything on the next edge.
    per_a = 10; idle(20);
    enable_a = 1'b1; t0 = cyc;
    push_a(1, 10, 10, 1, 0, 0, t0);
    drain(200);
    idle(30);
    sys_rst = 1'b1; enable_a = 1'b0;
    idle(1);
    chk("midrst_freq_count", longint'(freq_count_a), 0);
    chk("midrst_count_valid", longint'(count_valid_a), 0);
    chk("midrst_in_range", longint'(in_range_a), 0);
    chk("midrst_dead", longint'(dead_a), 0);
    chk("midrst_overflow", longint'(overflow_a), 0);
    sys_rst = 1'b0;
    idle(150);
    chk("leftover_expected", longint'(q_a.size() + q_b.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
